rx_mac: RTL and testbench

Receive-side 10G Ethernet MAC for the 32-bit XGMII datapath, the counterpart of `tx_mac`. It sits between the PCS receive output and the user logic. It does the following:
- detects Start and checks the preamble/SFD;
- strips preamble and FCS;
- checks the CRC-32;
- delivers the payload as an AXI-Stream master, with `tuser` flagging bad frames.

There is no backpressure. Frames arrive at line rate and are emitted at line rate.

---
 rtl/eth_pkg.sv | 38 +++
 rtl/crc32_rx_update.sv | 33 +++
 rtl/rx_mac.sv | 221 ++++++++++++++++++++++
 tb/tb_rx_mac.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : XGMII character codes, CRC-32 constants and rx_mac FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam logic [7:0] c_start = 8'hFB;
    localparam logic [7:0] c_term  = 8'hFD;
    localparam logic [7:0] c_error = 8'hFE;
    localparam logic [7:0] c_idle  = 8'h07;
    localparam logic [7:0] c_pre   = 8'h55;
    localparam logic [7:0] c_sfd   = 8'hD5;

    localparam logic [31:0] c_crc_poly    = 32'hEDB88320;
    localparam logic [31:0] c_crc_init    = 32'hFFFFFFFF;
    localparam logic [31:0] c_crc_residue = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_FLUSH    = 2'd3
    } rx_state_t;

    // Byte count 1..3 maps to a contiguous keep; 0 stands for a full word.
    function automatic logic [3:0] keep_for_bytes(input logic [1:0] n);
        case (n)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_rx_update.sv
`default_nettype none
// ============================================================================
// Module      : crc32_rx_update
// Description : Combinational reflected CRC-32 update over 1..4 bytes, lane 0 first.
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_rx_update
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    input  logic [2:0]  byte_count,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc_acc;

    always_comb begin
        w_crc_acc = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < byte_count) begin
                w_crc_acc = w_crc_acc ^ {24'h0, data[8*b +: 8]};
                for (int i = 0; i < 8; i++) begin
                    w_crc_acc = w_crc_acc[0] ? ((w_crc_acc >> 1) ^ c_crc_poly) : (w_crc_acc >> 1);
                end
            end
        end
    end

    assign crc_out = w_crc_acc;

endmodule
`default_nettype wire

// File: rtl/rx_mac.sv
`default_nettype none
// ============================================================================
// Module      : rx_mac
// Description : 10G Ethernet receive MAC, 32-bit XGMII in, AXI-Stream out.
//               Optional CRC checking enabled by macro RX_MAC_CRC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_mac
    import eth_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH  = 32,
    parameter int AXIS_DATA_BYTES  = AXIS_DATA_WIDTH / 8,
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8
) (
    input  logic                        rx_clk,
    input  logic                        rx_rst,
    input  logic [XGMII_DATA_WIDTH-1:0] in_xgmii_data,
    input  logic [XGMII_DATA_BYTES-1:0] in_xgmii_ctl,
    output logic [AXIS_DATA_WIDTH-1:0]  out_master_rx_tdata,
    output logic [AXIS_DATA_BYTES-1:0]  out_master_rx_tkeep,
    output logic                        out_master_rx_tvalid,
    output logic                        out_master_rx_tlast,
    output logic                        out_master_rx_tuser,
    output logic                        out_rx_good_frame,
    output logic                        out_rx_bad_frame
);

    rx_state_t r_state, w_state_next;

    logic [XGMII_DATA_WIDTH-1:0] r_word0, r_word1, w_word0_next, w_word1_next;
    logic                        r_valid0, r_valid1, w_valid0_next, w_valid1_next;
    logic                        r_err, w_err_next;
    logic [3:0]                  r_flush_keep, w_flush_keep_next;
    logic                        r_flush_bad, w_flush_bad_next;

    logic [AXIS_DATA_WIDTH-1:0]  w_tdata;
    logic [AXIS_DATA_BYTES-1:0]  w_tkeep;
    logic                        w_tvalid, w_tlast, w_tuser, w_good, w_bad;

    logic       w_start, w_preamble_ok, w_term, w_restart, w_crc_bad, w_frame_bad;
    logic [1:0] w_term_lane;

    assign w_start       = (in_xgmii_ctl == 4'b0001) &&
                           (in_xgmii_data == {c_pre, c_pre, c_pre, c_start});
    assign w_preamble_ok = (in_xgmii_ctl == 4'b0000) &&
                           (in_xgmii_data == {c_sfd, c_pre, c_pre, c_pre});

    // The lowest control lane decides; lanes below it are plain data.
    always_comb begin
        w_term_lane = 2'd0;
        if (in_xgmii_ctl[0])      w_term_lane = 2'd0;
        else if (in_xgmii_ctl[1]) w_term_lane = 2'd1;
        else if (in_xgmii_ctl[2]) w_term_lane = 2'd2;
        else if (in_xgmii_ctl[3]) w_term_lane = 2'd3;
    end

    assign w_term    = (|in_xgmii_ctl) &&
                       (in_xgmii_data[{w_term_lane, 3'b000} +: 8] == c_term);
    assign w_restart = in_xgmii_ctl[0] && (in_xgmii_data[7:0] == c_start);

`ifdef RX_MAC_CRC_CHECK_EN
    logic [31:0] r_crc, w_crc_word, w_crc_term_raw, w_crc_term;

    crc32_rx_update u_crc_word (
        .crc_in     (r_crc),
        .data       (in_xgmii_data),
        .byte_count (3'd4),
        .crc_out    (w_crc_word)
    );

    crc32_rx_update u_crc_term (
        .crc_in     (r_crc),
        .data       (in_xgmii_data),
        .byte_count ({1'b0, w_term_lane}),
        .crc_out    (w_crc_term_raw)
    );

    assign w_crc_term = (w_term_lane == 2'd0) ? r_crc : w_crc_term_raw;
    assign w_crc_bad  = (w_crc_term != c_crc_residue);

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            r_crc <= c_crc_init;
        end else if (r_state == ST_PREAMBLE) begin
            r_crc <= c_crc_init;
        end else if ((r_state == ST_DATA) && !w_term && !w_restart) begin
            r_crc <= w_crc_word;
        end
    end
`else
    assign w_crc_bad = 1'b0;
`endif

    assign w_frame_bad = r_err | w_restart | w_crc_bad;

    always_comb begin
        w_state_next      = r_state;
        w_word0_next      = r_word0;
        w_word1_next      = r_word1;
        w_valid0_next     = r_valid0;
        w_valid1_next     = r_valid1;
        w_err_next        = r_err;
        w_flush_keep_next = r_flush_keep;
        w_flush_bad_next  = r_flush_bad;
        w_tdata           = '0;
        w_tkeep           = '0;
        w_tvalid          = 1'b0;
        w_tlast           = 1'b0;
        w_tuser           = 1'b0;
        w_good            = 1'b0;
        w_bad             = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_next = ST_PREAMBLE;
            end

            ST_PREAMBLE: begin
                if (w_preamble_ok) begin
                    w_state_next  = ST_DATA;
                    w_valid0_next = 1'b0;
                    w_valid1_next = 1'b0;
                    w_err_next    = 1'b0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_DATA: begin
                if (w_term || w_restart) begin
                    w_valid0_next = 1'b0;
                    w_valid1_next = 1'b0;
                    // Without R0 the frame holds fewer than 8 bytes: drop it.
                    if (!r_valid0) begin
                        w_bad        = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_tdata  = r_word0;
                        w_tkeep  = 4'b1111;
                        w_tvalid = 1'b1;
                        if (w_term_lane == 2'd0) begin
                            w_tlast      = 1'b1;
                            w_tuser      = w_frame_bad;
                            w_good       = ~w_frame_bad;
                            w_bad        = w_frame_bad;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_flush_keep_next = keep_for_bytes(w_term_lane);
                            w_flush_bad_next  = w_frame_bad;
                            w_state_next      = ST_FLUSH;
                        end
                    end
                end else begin
                    if (in_xgmii_ctl != 4'b0000) w_err_next = 1'b1;
                    w_word0_next  = r_word1;
                    w_valid0_next = r_valid1;
                    w_word1_next  = in_xgmii_data;
                    w_valid1_next = 1'b1;
                    if (r_valid0) begin
                        w_tdata  = r_word0;
                        w_tkeep  = 4'b1111;
                        w_tvalid = 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                w_tdata      = r_word1 & {{8{r_flush_keep[3]}}, {8{r_flush_keep[2]}},
                                          {8{r_flush_keep[1]}}, {8{r_flush_keep[0]}}};
                w_tkeep      = r_flush_keep;
                w_tvalid     = 1'b1;
                w_tlast      = 1'b1;
                w_tuser      = r_flush_bad;
                w_good       = ~r_flush_bad;
                w_bad        = r_flush_bad;
                w_state_next = ST_IDLE;
            end

            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            r_state              <= ST_IDLE;
            r_word0              <= '0;
            r_word1              <= '0;
            r_valid0             <= 1'b0;
            r_valid1             <= 1'b0;
            r_err                <= 1'b0;
            r_flush_keep         <= '0;
            r_flush_bad          <= 1'b0;
            out_master_rx_tdata  <= '0;
            out_master_rx_tkeep  <= '0;
            out_master_rx_tvalid <= 1'b0;
            out_master_rx_tlast  <= 1'b0;
            out_master_rx_tuser  <= 1'b0;
            out_rx_good_frame    <= 1'b0;
            out_rx_bad_frame     <= 1'b0;
        end else begin
            r_state              <= w_state_next;
            r_word0              <= w_word0_next;
            r_word1              <= w_word1_next;
            r_valid0             <= w_valid0_next;
            r_valid1             <= w_valid1_next;
            r_err                <= w_err_next;
            r_flush_keep         <= w_flush_keep_next;
            r_flush_bad          <= w_flush_bad_next;
            out_master_rx_tdata  <= w_tdata;
            out_master_rx_tkeep  <= w_tkeep;
            out_master_rx_tvalid <= w_tvalid;
            out_master_rx_tlast  <= w_tlast;
            out_master_rx_tuser  <= w_tuser;
            out_rx_good_frame    <= w_good;
            out_rx_bad_frame     <= w_bad;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_mac
// Description : Directed scoreboard bench for rx_mac (honours RX_MAC_CRC_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_mac;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic        good;
        logic        bad;
    } beat_t;

    logic        clk = 1'b0;
    logic        rx_rst;
    logic [31:0] xd;
    logic [3:0]  xc;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid, tlast, tuser, good_p, bad_p;

    beat_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    good_cnt = 0;
    int    bad_cnt  = 0;
    int    exp_good = 0;
    int    exp_bad  = 0;
    bit    ignore_out = 1'b0;

    always #5 clk = ~clk;

    rx_mac dut (
        .rx_clk               (clk),
        .rx_rst               (rx_rst),
        .in_xgmii_data        (xd),
        .in_xgmii_ctl         (xc),
        .out_master_rx_tdata  (tdata),
        .out_master_rx_tkeep  (tkeep),
        .out_master_rx_tvalid (tvalid),
        .out_master_rx_tlast  (tlast),
        .out_master_rx_tuser  (tuser),
        .out_rx_good_frame    (good_p),
        .out_rx_bad_frame     (bad_p)
    );

    function automatic logic [31:0] crc32(input logic [7:0] bytes[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (bytes[i]) begin
            c = c ^ {24'h0, bytes[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] keep_mask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    always @(negedge clk) begin
        beat_t e, o;
        if (rx_rst && !ignore_out) begin
            if (good_p) good_cnt++;
            if (bad_p)  bad_cnt++;
            if (tvalid) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed tdata=%h tlast=%b required no beat", tdata, tlast);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    o.data = tdata & keep_mask(e.keep);
                    o.keep = tkeep;
                    o.last = tlast;
                    o.user = tuser;
                    o.good = good_p;
                    o.bad  = bad_p;
                    checks++;
                    assert (o === e) else begin
                        errors++;
                        $error("FAIL beat observed=%h required=%h", o, e);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [31:0] d, input logic [3:0] c);
        @(negedge clk);
        xd = d;
        xc = c;
    endtask

    // Builds payload+FCS, queues the expected beats, then drives the frame.
    task automatic send_frame(input int n_pay, input int flip_byte, input int err_word,
                              input bit bad_sfd, input int ifg_words);
        logic [7:0]  tx[$];
        logic [31:0] fcs, w;
        int          total, nwords, k;
        bit          exp_user;
        beat_t       b;
        for (int i = 0; i < n_pay; i++) tx.push_back(8'($urandom));
        fcs = ~crc32(tx);
        for (int i = 0; i < 4; i++) tx.push_back(fcs[8*i +: 8]);
        if (flip_byte >= 0) tx[flip_byte] = tx[flip_byte] ^ 8'h01;
        if (err_word >= 0)  tx[4*err_word+1] = 8'hFE;
        total  = n_pay + 4;
        nwords = total / 4;
        k      = total % 4;
`ifdef RX_MAC_CRC_CHECK_EN
        exp_user = (flip_byte >= 0) || (err_word >= 0);
`else
        exp_user = (err_word >= 0);
`endif
        if (!bad_sfd && total >= 8) begin
            for (int i = 0; i < n_pay; i += 4) begin
                b = '0;
                for (int j = 0; j < 4 && i + j < n_pay; j++) begin
                    b.data[8*j +: 8] = tx[i+j];
                    b.keep[j]        = 1'b1;
                end
                b.last = (i + 4 >= n_pay);
                b.user = b.last & exp_user;
                b.good = b.last & !exp_user;
                b.bad  = b.last & exp_user;
                exp_q.push_back(b);
            end
            if (exp_user) exp_bad++;
            else          exp_good++;
        end else if (!bad_sfd) begin
            exp_bad++;
        end
        drive(32'h555555FB, 4'b0001);
        drive(bad_sfd ? 32'hD4555555 : 32'hD5555555, 4'b0000);
        for (int wi = 0; wi < nwords; wi++) begin
            w = {tx[4*wi+3], tx[4*wi+2], tx[4*wi+1], tx[4*wi]};
            drive(w, (wi == err_word) ? 4'b0010 : 4'b0000);
        end
        w = 32'h07070707;
        for (int j = 0; j < k; j++) w[8*j +: 8] = tx[4*nwords+j];
        w[8*k +: 8] = 8'hFD;
        drive(w, 4'(4'hF << k));
        repeat (ifg_words) drive(32'h07070707, 4'hF);
    endtask

    task automatic check_frame(input string tag);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain observed pending=%0d required=0", tag, exp_q.size());
        end
        checks++;
        assert (good_cnt === exp_good) else begin
            errors++;
            $error("FAIL %s_good observed=%0d required=%0d", tag, good_cnt, exp_good);
        end
        checks++;
        assert (bad_cnt === exp_bad) else begin
            errors++;
            $error("FAIL %s_bad observed=%0d required=%0d", tag, bad_cnt, exp_bad);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout observed=no finish required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rx_rst = 1'b0;
        xd     = 32'h07070707;
        xc     = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        assert ({tdata, tkeep, tvalid, tlast, tuser, good_p, bad_p} === 41'h0) else begin
            errors++;
            $error("FAIL reset_outputs observed=%h required=0",
                   {tdata, tkeep, tvalid, tlast, tuser, good_p, bad_p});
        end
        rx_rst = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(60, -1, -1, 1'b0, 3);  check_frame("good60");
        send_frame(62, -1, -1, 1'b0, 3);  check_frame("partial62");
        send_frame(60, 10, -1, 1'b0, 3);  check_frame("crc_err");
        send_frame(60, -1,  5, 1'b0, 3);  check_frame("err_char");
        send_frame(60, -1, -1, 1'b1, 3);
        send_frame(61, -1, -1, 1'b0, 3);  check_frame("bad_sfd");
        send_frame(2,  -1, -1, 1'b0, 3);  check_frame("runt6");
        send_frame(4,  -1, -1, 1'b0, 3);  check_frame("min8");
        send_frame(5,  -1, -1, 1'b0, 3);  check_frame("min9");

        // Abort a frame mid-payload with reset.
        ignore_out = 1'b1;
        drive(32'h555555FB, 4'b0001);
        drive(32'hD5555555, 4'b0000);
        for (int i = 0; i < 6; i++) drive(32'($urandom), 4'b0000);
        #1;
        checks++;
        assert (tvalid === 1'b1) else begin
            errors++;
            $error("FAIL pre_reset_tvalid observed=%b required=1", tvalid);
        end
        #1 rx_rst = 1'b0;
        #1;
        checks++;
        assert ({tdata, tkeep, tvalid, tlast, tuser, good_p, bad_p} === 41'h0) else begin
            errors++;
            $error("FAIL reset_async observed=%h required=0",
                   {tdata, tkeep, tvalid, tlast, tuser, good_p, bad_p});
        end
        xd = 32'h07070707;
        xc = 4'hF;
        repeat (2) @(negedge clk);
        rx_rst = 1'b1;
        @(negedge clk);
        ignore_out = 1'b0;
        send_frame(63, -1, -1, 1'b0, 3);  check_frame("post_reset");

        send_frame(60, -1, -1, 1'b0, 3);
        send_frame(57, -1, -1, 1'b0, 3);  check_frame("b2b_ifg12");
        send_frame(61, -1, -1, 1'b0, 1);
        send_frame(60, -1, -1, 1'b0, 1);  check_frame("b2b_flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
